// File: rtl/fairy_fetch_ctrl.sv
// fairy_fetch_ctrl: fetch PC sequencing FSM (boot, run, stall with pending branch, flush on exception/eret).
// Optional perf counters built only when FAIRY_FETCH_PERF_EN is defined.
module fairy_fetch_ctrl (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        exception_i,
  input  logic        eret_i,
  input  logic [31:0] epc_i,
  input  logic        branch_valid_i,
  input  logic [31:0] branch_target_i,
  input  logic        hazard_stall_i,
  input  logic        mem_busy_i,
  input  logic [31:0] pc_i,
  output logic [31:0] next_pc_o,
  output logic        pc_we_o,
  output logic        fetch_stall_o,
  output logic        flush_o,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt_o,
  output logic [31:0] redirect_cnt_o
);
  localparam logic [1:0] BOOT = 2'b00, RUN = 2'b01, STALL = 2'b10, FLUSH = 2'b11;
  localparam logic [31:0] RST_VEC = 32'hBFC00000, EXC_VEC = 32'hBFC00380;
  logic [1:0]  state, state_nx;
  logic        pend_v, stall, redirect, hold;
  logic [31:0] pend_t;
  assign stall    = hazard_stall_i | mem_busy_i;
  assign redirect = reset_n && state != BOOT && (exception_i || eret_i);
  // a stalled RUN/STALL cycle that is not being redirected captures any branch
  assign hold     = reset_n && (state == RUN || state == STALL) && !redirect && stall;
  assign state_o  = state;
  always_comb begin
    state_nx      = state;
    next_pc_o     = pc_i + 32'd4;
    pc_we_o       = 1'b0;
    fetch_stall_o = 1'b1;
    if (!reset_n) begin
      next_pc_o = RST_VEC;
      state_nx  = BOOT;
    end else if (state == BOOT) begin
      next_pc_o = RST_VEC;
      state_nx  = RUN;
    end else if (redirect) begin
      next_pc_o     = exception_i ? EXC_VEC : epc_i;
      pc_we_o       = 1'b1;
      fetch_stall_o = 1'b0;
      state_nx      = FLUSH;
    end else if (state == FLUSH) begin
      state_nx = RUN;
    end else if (stall) begin
      state_nx = STALL;
    end else begin
      next_pc_o     = pend_v ? pend_t : branch_valid_i ? branch_target_i : pc_i + 32'd4;
      pc_we_o       = 1'b1;
      fetch_stall_o = 1'b0;
      state_nx      = RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= BOOT;
      pend_v  <= 1'b0;
      pend_t  <= '0;
      flush_o <= 1'b0;
    end else begin
      state   <= state_nx;
      flush_o <= redirect;
      if (hold && branch_valid_i) begin
        pend_v <= 1'b1;
        pend_t <= branch_target_i;
      end else if (!hold) begin
        pend_v <= 1'b0;
      end
    end
  end
`ifdef FAIRY_FETCH_PERF_EN
  logic [31:0] stall_cnt, redirect_cnt;
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_cnt    <= '0;
      redirect_cnt <= '0;
    end else begin
      stall_cnt    <= stall_cnt + {31'd0, fetch_stall_o};
      redirect_cnt <= redirect_cnt + {31'd0, redirect};
    end
  end
  assign stall_cnt_o    = stall_cnt;
  assign redirect_cnt_o = redirect_cnt;
`else
  assign stall_cnt_o    = '0;
  assign redirect_cnt_o = '0;
`endif
endmodule

// File: tb/tb_fairy_fetch_ctrl.sv
// tb_fairy_fetch_ctrl: directed and random stimulus, expected outputs from a behavioural model via a scoreboard queue.
module tb_fairy_fetch_ctrl;
  logic        clk = 1'b0, reset_n = 1'b0, exception_i = 1'b0, eret_i = 1'b0;
  logic        branch_valid_i = 1'b0, hazard_stall_i = 1'b0, mem_busy_i = 1'b0;
  logic [31:0] epc_i = '0, branch_target_i = '0, pc_i = '0;
  logic [31:0] next_pc_o, stall_cnt_o, redirect_cnt_o;
  logic        pc_we_o, fetch_stall_o, flush_o;
  logic [1:0]  state_o;
  always #5 clk = ~clk;
  fairy_fetch_ctrl dut (
    .clk(clk), .reset_n(reset_n), .exception_i(exception_i), .eret_i(eret_i), .epc_i(epc_i),
    .branch_valid_i(branch_valid_i), .branch_target_i(branch_target_i),
    .hazard_stall_i(hazard_stall_i), .mem_busy_i(mem_busy_i), .pc_i(pc_i),
    .next_pc_o(next_pc_o), .pc_we_o(pc_we_o), .fetch_stall_o(fetch_stall_o), .flush_o(flush_o),
    .state_o(state_o), .stall_cnt_o(stall_cnt_o), .redirect_cnt_o(redirect_cnt_o)
  );
  typedef struct {
    logic        chk_pc;
    logic [31:0] pc;
    logic        we, fs, fl;
    logic [1:0]  st;
    logic [31:0] sc, rc;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0;
  // behavioural model: phase flags plus a list of latched branch targets (newest wins)
  bit          booted, flushing, stalled, flush_out;
  logic [31:0] pend[$];
  logic [31:0] scnt, rcnt;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("pc_we", {31'd0, pc_we_o}, {31'd0, e.we});
      check("fetch_stall", {31'd0, fetch_stall_o}, {31'd0, e.fs});
      check("flush", {31'd0, flush_o}, {31'd0, e.fl});
      check("state", {30'd0, state_o}, {30'd0, e.st});
      check("stall_cnt", stall_cnt_o, e.sc);
      check("redirect_cnt", redirect_cnt_o, e.rc);
      if (e.chk_pc) check("next_pc", next_pc_o, e.pc);
    end
  end
  task automatic cyc(input logic r, input logic e, input logic er, input logic [31:0] ep,
                     input logic b, input logic [31:0] t, input logic h, input logic m,
                     input logic [31:0] p);
    exp_t x;
    bit redir, stl;
    reset_n = r; exception_i = e; eret_i = er; epc_i = ep;
    branch_valid_i = b; branch_target_i = t; hazard_stall_i = h; mem_busy_i = m; pc_i = p;
    redir = r && booted && (e || er);
    stl = h || m;
    x.chk_pc = 1'b0; x.pc = '0; x.we = 1'b0; x.fs = 1'b1;
    x.fl = flush_out;
    x.st = !booted ? 2'b00 : flushing ? 2'b11 : stalled ? 2'b10 : 2'b01;
`ifdef FAIRY_FETCH_PERF_EN
    x.sc = scnt; x.rc = rcnt;
`else
    x.sc = '0; x.rc = '0;
`endif
    if (!r) begin
      x.chk_pc = 1'b1; x.pc = 32'hBFC00000;
    end else if (!booted) begin
    end else if (redir) begin
      x.chk_pc = 1'b1; x.we = 1'b1; x.fs = 1'b0; x.pc = e ? 32'hBFC00380 : ep;
    end else if (flushing || stl) begin
    end else begin
      x.chk_pc = 1'b1; x.we = 1'b1; x.fs = 1'b0;
      x.pc = pend.size() > 0 ? pend[$] : b ? t : p + 32'd4;
    end
    q.push_back(x);
    @(posedge clk);
    if (!r) begin
      booted = 0; flushing = 0; stalled = 0; flush_out = 0; pend.delete(); scnt = '0; rcnt = '0;
    end else begin
      flush_out = redir;
      scnt = scnt + {31'd0, x.fs};
      rcnt = rcnt + {31'd0, redir};
      if (!booted) booted = 1;
      else if (redir) begin flushing = 1; stalled = 0; pend.delete(); end
      else if (flushing) flushing = 0;
      else if (stl) begin stalled = 1; if (b) pend.push_back(t); end
      else begin stalled = 0; pend.delete(); end
    end
    #1;
  endtask
  task automatic idle(input logic [31:0] p);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, p);
  endtask
  initial begin
    booted = 0; flushing = 0; stalled = 0; flush_out = 0; scnt = '0; rcnt = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 32'hBFC00000);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'hBFC00000);
    idle(32'hBFC00000);
    cyc(1, 0, 0, 0, 1, 32'hBFC00100, 0, 0, 32'hBFC00004);
    cyc(1, 0, 0, 0, 1, 32'h80001000, 1, 0, 32'hBFC00100);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'hBFC00100);
    cyc(1, 0, 0, 0, 0, 0, 1, 0, 32'hBFC00100);
    idle(32'hBFC00100);
    cyc(1, 0, 0, 0, 1, 32'h00001234, 0, 1, 32'h80001000);
    cyc(1, 1, 0, 0, 0, 0, 1, 0, 32'h80001000);
    idle(32'hBFC00380);
    idle(32'hBFC00380);
    cyc(1, 0, 1, 32'hBFC00040, 0, 0, 0, 0, 32'hBFC00384);
    idle(32'hBFC00040);
    idle(32'hBFC00040);
    cyc(1, 0, 0, 0, 1, 32'h00002000, 1, 0, 32'h00000100);
    cyc(0, 0, 0, 0, 0, 0, 1, 0, 32'h00000100);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 32'h00000100);
    idle(32'h00000100);
    cyc(1, 1, 0, 0, 0, 0, 0, 0, 32'h00000104);
    cyc(1, 0, 1, 32'h00000500, 0, 0, 0, 0, 32'hBFC00380);
    idle(32'h00000500);
    idle(32'hFFFFFFFC);
    for (int i = 0; i < 3000; i++) begin
      logic [31:0] tgt, pcv;
      tgt = $urandom & 32'hFFFFFFFC;
      pcv = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC : ($urandom & 32'hFFFFFFFC);
      cyc($urandom_range(0, 99) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 14) == 0,
          $urandom, $urandom_range(0, 2) == 0, tgt, $urandom_range(0, 3) == 0,
          $urandom_range(0, 5) == 0, pcv);
    end
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d entries left expected 0", q.size());
    end
    #2;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
